posi_md_ram_ctrl: RTL and testbench

POSI_MD_RAM_CTRL -- requirements
Module: posi_md_ram_ctrl

---
 rtl/posi_md_ram_ctrl_if.sv | 32 +++
 rtl/posi_md_ram_ctrl.sv | 96 +++++++++
 tb/tb_posi_md_ram_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/posi_md_ram_ctrl_if.sv
// posi_md_ram_ctrl_if: request/ack, read-result and RAM-side bus of the RAM controller
interface posi_md_ram_ctrl_if #(
  parameter int ADR_WD = 6,
  parameter int DAT_WD = 6
);
  logic              wr_req_i;
  logic [ADR_WD-1:0] wr_adr_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              wr_ack_o;
  logic              rd_req_i;
  logic [ADR_WD-1:0] rd_adr_i;
  logic              rd_ack_o;
  logic              rd_val_o;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              clr_i;
  logic              busy_o;
  logic [ADR_WD-1:0] ram_adr_o;
  logic              ram_wr_ena_o;
  logic [DAT_WD-1:0] ram_wr_dat_o;
  logic              ram_rd_ena_o;
  logic [DAT_WD-1:0] ram_rd_dat_i;
  modport master (
    output wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i, clr_i, ram_rd_dat_i,
    input  wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o, busy_o,
           ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
  );
  modport slave (
    input  wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i, clr_i, ram_rd_dat_i,
    output wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o, busy_o,
           ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
  );
endinterface

// File: rtl/posi_md_ram_ctrl.sv
// posi_md_ram_ctrl: single-port RAM arbiter (write over read) with zero-fill sweep; POSI_MD_INIT_EN auto-clears after reset
module posi_md_ram_ctrl #(
  parameter int ADR_WD = 6,
  parameter int ADR    = 64,
  parameter int DAT_WD = 6
) (
  input logic clk,
  input logic rst,
  posi_md_ram_ctrl_if.slave bus
);
  typedef enum logic {IDLE, CLR} state_t;
  localparam logic [ADR_WD-1:0] LAST = ADR_WD'(ADR - 1);
  state_t state, state_n;
  logic [ADR_WD-1:0] cnt, cnt_n, adr_q, adr_n;
  logic [DAT_WD-1:0] dat_q, dat_n;
  logic we_q, we_n, re_q, re_n, v1_q, val_q, clr_go, wr_ack, rd_ack;
`ifdef POSI_MD_INIT_EN
  logic init_q;
  // one-shot clear request for the first edge after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) init_q <= 1'b1;
    else init_q <= 1'b0;
  assign clr_go = bus.clr_i | init_q;
`else
  assign clr_go = bus.clr_i;
`endif
  // grant and next RAM access; the RAM port is registered so acks present their access one cycle later
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    adr_n   = adr_q;
    dat_n   = dat_q;
    we_n    = 1'b1;
    re_n    = 1'b1;
    wr_ack  = 1'b0;
    rd_ack  = 1'b0;
    if (state == IDLE) begin
      if (clr_go) begin
        state_n = CLR;
        cnt_n   = '0;
        adr_n   = '0;
        dat_n   = '0;
        we_n    = 1'b0;
      end else begin
        wr_ack = bus.wr_req_i & ~rst;
        rd_ack = bus.rd_req_i & ~bus.wr_req_i & ~rst;
        if (wr_ack) begin
          adr_n = bus.wr_adr_i;
          dat_n = bus.wr_dat_i;
          we_n  = 1'b0;
        end else if (rd_ack) begin
          adr_n = bus.rd_adr_i;
          re_n  = 1'b0;
        end
      end
    end else if (cnt == LAST) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt + 1'b1;
      adr_n = cnt + 1'b1;
      dat_n = '0;
      we_n  = 1'b0;
    end
  end
  // state, sweep counter, RAM port registers and the two-stage read-valid pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b1;
      re_q  <= 1'b1;
      v1_q  <= 1'b0;
      val_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      adr_q <= adr_n;
      dat_q <= dat_n;
      we_q  <= we_n;
      re_q  <= re_n;
      v1_q  <= rd_ack;
      val_q <= v1_q;
    end
  assign bus.wr_ack_o     = wr_ack;
  assign bus.rd_ack_o     = rd_ack;
  assign bus.busy_o       = state == CLR;
  assign bus.rd_val_o     = val_q;
  assign bus.rd_dat_o     = val_q ? bus.ram_rd_dat_i : '0;
  assign bus.ram_adr_o    = adr_q;
  assign bus.ram_wr_dat_o = dat_q;
  assign bus.ram_wr_ena_o = we_q;
  assign bus.ram_rd_ena_o = re_q;
endmodule

// File: tb/tb_posi_md_ram_ctrl.sv
// tb_posi_md_ram_ctrl: directed bench with RAM model, shadow memory and read scoreboard
module tb_posi_md_ram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct { logic [5:0] d; int due; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [5:0] shadow [64];
  logic [5:0] mem [64];
  logic pend_v = 1'b0, pend_we;
  logic [5:0] pend_adr, pend_dat;
  int sw = 0;
  posi_md_ram_ctrl_if #(.ADR_WD(6), .DAT_WD(6)) b ();
  posi_md_ram_ctrl #(.ADR_WD(6), .ADR(64), .DAT_WD(6)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // synchronous RAM: write and registered read on the rising edge
  always @(posedge clk) begin
    if (!b.ram_wr_ena_o) mem[b.ram_adr_o] <= b.ram_wr_dat_o;
    if (!b.ram_rd_ena_o) b.ram_rd_dat_i <= mem[b.ram_adr_o];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // monitor: RAM access timing, sweep addresses, read results against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pend_v = 1'b0;
      sw = 0;
    end else begin
      chk("one_ack", 32'(b.wr_ack_o & b.rd_ack_o), 0);
      if (b.rd_val_o) begin
        if (q.size() == 0) chk("rd_val_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rd_dat", 32'(b.rd_dat_o), 32'(e.d));
          chk("rd_latency", cyc, e.due);
        end
      end else chk("rd_dat_zero", 32'(b.rd_dat_o), 0);
      if (b.busy_o) begin
        chk("clr_adr", 32'(b.ram_adr_o), sw);
        chk("clr_we", 32'(b.ram_wr_ena_o), 0);
        chk("clr_dat", 32'(b.ram_wr_dat_o), 0);
        chk("clr_noack", 32'(b.wr_ack_o | b.rd_ack_o), 0);
        shadow[b.ram_adr_o] = 6'd0;
        sw++;
        pend_v = 1'b0;
      end else begin
        sw = 0;
        if (pend_v) begin
          chk("acc_we", 32'(b.ram_wr_ena_o), pend_we ? 0 : 1);
          chk("acc_re", 32'(b.ram_rd_ena_o), pend_we ? 1 : 0);
          chk("acc_adr", 32'(b.ram_adr_o), 32'(pend_adr));
          if (pend_we) chk("acc_dat", 32'(b.ram_wr_dat_o), 32'(pend_dat));
        end else begin
          chk("idle_we", 32'(b.ram_wr_ena_o), 1);
          chk("idle_re", 32'(b.ram_rd_ena_o), 1);
        end
        pend_v = 1'b0;
        if (b.wr_ack_o) begin
          shadow[b.wr_adr_i] = b.wr_dat_i;
          pend_v = 1'b1; pend_we = 1'b1; pend_adr = b.wr_adr_i; pend_dat = b.wr_dat_i;
        end else if (b.rd_ack_o) begin
          q.push_back('{shadow[b.rd_adr_i], cyc + 2});
          pend_v = 1'b1; pend_we = 1'b0; pend_adr = b.rd_adr_i;
        end
      end
    end
  end
  task automatic wr(input logic [5:0] a, input logic [5:0] d, output int lat);
    b.wr_req_i = 1'b1; b.wr_adr_i = a; b.wr_dat_i = d;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b.wr_ack_o) begin lat = i; break; end
    end
    chk("wr_ack_wait", 32'(lat >= 0), 1);
    @(posedge clk) #1 b.wr_req_i = 1'b0;
  endtask
  task automatic rd(input logic [5:0] a);
    int lat = -1;
    b.rd_req_i = 1'b1; b.rd_adr_i = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b.rd_ack_o) begin lat = i; break; end
    end
    chk("rd_ack_wait", 32'(lat >= 0), 1);
    @(posedge clk) #1 b.rd_req_i = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    for (int i = 0; i < 200 && b.busy_o; i++) begin @(negedge clk); n++; end
    chk("idle_wait", 32'(b.busy_o), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, n;
    b.wr_req_i = 1'b1; b.wr_adr_i = '0; b.wr_dat_i = '0;
    b.rd_req_i = 1'b0; b.rd_adr_i = '0; b.clr_i = 1'b0;
    #12;
    chk("rst_busy", 32'(b.busy_o), 0);
    chk("rst_we", 32'(b.ram_wr_ena_o), 1);
    chk("rst_re", 32'(b.ram_rd_ena_o), 1);
    chk("rst_adr", 32'(b.ram_adr_o), 0);
    chk("rst_dat", 32'(b.ram_wr_dat_o), 0);
    chk("rst_val", 32'(b.rd_val_o), 0);
    chk("rst_rdat", 32'(b.rd_dat_o), 0);
    chk("rst_ack", 32'(b.wr_ack_o | b.rd_ack_o), 0);
    b.wr_req_i = 1'b0;
    @(posedge clk) #1 rst = 1'b0;
`ifdef POSI_MD_INIT_EN
    @(negedge clk);
    chk("init_busy", 32'(b.busy_o), 1);
    wait_idle();
    @(posedge clk) #1;
`endif
    wr(6'd5, 6'h2A, lat);
    chk("wr_ack_immediate", lat, 0);
    rd(6'd5);
    b.wr_req_i = 1'b1; b.wr_adr_i = 6'd9; b.wr_dat_i = 6'h15;
    b.rd_req_i = 1'b1; b.rd_adr_i = 6'd9;
    @(negedge clk);
    chk("sim_wr_ack", 32'(b.wr_ack_o), 1);
    chk("sim_rd_ack", 32'(b.rd_ack_o), 0);
    @(posedge clk) #1 b.wr_req_i = 1'b0;
    @(negedge clk);
    chk("sim_rd_ack_next", 32'(b.rd_ack_o), 1);
    @(posedge clk) #1 b.rd_req_i = 1'b0;
    wr(6'd1, 6'h11, lat);
    wr(6'd2, 6'h22, lat);
    wr(6'd3, 6'h33, lat);
    wr(6'd33, 6'h3C, lat);
    wr(6'd63, 6'h07, lat);
    wr(6'd0, 6'h19, lat);
    b.rd_req_i = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      b.rd_adr_i = 6'(a);
      @(negedge clk);
      chk("b2b_ack", 32'(b.rd_ack_o), 1);
      @(posedge clk) #1;
    end
    b.rd_req_i = 1'b0;
    rd(6'd5);
    b.clr_i = 1'b1;
    b.wr_req_i = 1'b1; b.wr_adr_i = 6'd7; b.wr_dat_i = 6'h01;
    @(negedge clk);
    chk("clr_prec_ack", 32'(b.wr_ack_o | b.rd_ack_o), 0);
    chk("clr_busy_lag", 32'(b.busy_o), 0);
    @(posedge clk) #1 b.clr_i = 1'b0; b.wr_req_i = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!b.busy_o) break;
      n++;
      b.clr_i = (n == 10);
    end
    b.clr_i = 1'b0;
    chk("busy_len", n, 64);
    @(posedge clk) #1;
    rd(6'd0);
    rd(6'd33);
    rd(6'd63);
    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    @(posedge clk) #1 b.clr_i = 1'b1;
    @(posedge clk) #1 b.clr_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b.busy_o && b.ram_adr_o == 6'd20) break;
    end
    chk("sweep_at_20", 32'(b.ram_adr_o), 20);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(b.busy_o), 0);
    chk("arst_we", 32'(b.ram_wr_ena_o), 1);
    chk("arst_re", 32'(b.ram_rd_ena_o), 1);
    chk("arst_adr", 32'(b.ram_adr_o), 0);
    chk("arst_dat", 32'(b.ram_wr_dat_o), 0);
    chk("arst_val", 32'(b.rd_val_o), 0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
`ifdef POSI_MD_INIT_EN
    chk("restart_busy", 32'(b.busy_o), 1);
    chk("restart_adr", 32'(b.ram_adr_o), 0);
    wait_idle();
`else
    chk("post_rst_busy", 32'(b.busy_o), 0);
`endif
    @(posedge clk) #1;
    wr(6'd40, 6'h2D, lat);
`ifndef POSI_MD_INIT_EN
    chk("post_rst_ack_immediate", lat, 0);
`endif
    rd(6'd40);
    repeat (4) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
